imem_loader: RTL

Instruction-memory responder for the pipelined processor: holds the program image and answers the fetch side combinationally with the 32-bit instruction word addressed by PC. A byte-serial load port, driven by the test host or a boot controller, fills the memory through a valid/ready handshake. While no complete program is present, the block returns NOP words and holds the core in stall.

---
 rtl/imem_loader.sv | 134 +++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Instruction memory with a byte-serial valid/ready load port; the core is held until a load completes.
// Optional feature: define IMEM_CHECKSUM_EN to build the load_sum byte-checksum accumulator.
`timescale 1ns/1ps
module imem_loader #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              load_start,
   input  logic              load_valid,
   input  logic [7:0]        load_byte,
   input  logic              load_end,
   output logic              load_ready,
   output logic              load_ovf,
   output logic [ADDR_W:0]   word_count,
   output logic              cpu_hold,
   input  logic [31:0]       pc,
   output logic [31:0]       instruction,
   output logic [7:0]        load_sum,
   output logic [1:0]        fsm_state
);

   localparam int DEPTH = 2 ** ADDR_W;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_FLUSH = 2'd2;
   localparam logic [1:0] ST_RUN   = 2'd3;

   logic [1:0]  state;
   logic [1:0]  byte_idx;
   logic [31:0] shift_reg;
   logic [31:0] mem [DEPTH];

   logic        full;
   logic        restart;
   logic        accept;
   logic [1:0]  idx_next;
   logic [31:0] assembled;
   logic [31:0] flush_word;
   logic        mem_we;
   logic [31:0] mem_wdata;
   logic        pc_in_range;

   // Handshake: a byte transfers on a rising clk edge where load_valid and load_ready
   // are both high; load_ready is high only in LOAD while memory has a free word.
   assign full       = word_count[ADDR_W];
   assign restart    = load_start && (state != ST_FLUSH);
   assign accept     = (state == ST_LOAD) && load_valid && !full && !restart;
   assign idx_next   = byte_idx + {1'b0, accept};
   assign assembled  = {shift_reg[23:0], load_byte};
   assign load_ready = (state == ST_LOAD) && !full;
   assign cpu_hold   = (state != ST_RUN);
   assign fsm_state  = state;

   always_comb begin
      flush_word = 32'h0;
      case (byte_idx)
         2'd1:    flush_word = {shift_reg[7:0], 24'h0};
         2'd2:    flush_word = {shift_reg[15:0], 16'h0};
         2'd3:    flush_word = {shift_reg[23:0], 8'h0};
         default: flush_word = 32'h0;
      endcase
   end

   always_comb begin
      mem_we    = 1'b0;
      mem_wdata = assembled;
      if (accept && byte_idx == 2'd3) begin
         mem_we = 1'b1;
      end else if (state == ST_FLUSH && !full) begin
         mem_we    = 1'b1;
         mem_wdata = flush_word;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem[word_count[ADDR_W-1:0]] <= mem_wdata;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         word_count <= '0;
         load_ovf   <= 1'b0;
         byte_idx   <= 2'd0;
         shift_reg  <= 32'h0;
      end else if (restart) begin
         state      <= ST_LOAD;
         word_count <= '0;
         load_ovf   <= 1'b0;
         byte_idx   <= 2'd0;
         shift_reg  <= 32'h0;
      end else begin
         case (state)
            ST_LOAD: begin
               if (accept) begin
                  shift_reg <= assembled;
                  byte_idx  <= idx_next;
                  if (byte_idx == 2'd3) word_count <= word_count + 1'b1;
               end
               if (load_valid && full) load_ovf <= 1'b1;
               // The end pulse sees the byte index after any byte taken this cycle.
               if (load_end) state <= (idx_next == 2'd0) ? ST_RUN : ST_FLUSH;
            end
            ST_FLUSH: begin
               if (full) load_ovf <= 1'b1;
               else      word_count <= word_count + 1'b1;
               byte_idx  <= 2'd0;
               shift_reg <= 32'h0;
               state     <= ST_RUN;
            end
            default: ;
         endcase
      end
   end

`ifdef IMEM_CHECKSUM_EN
   logic [7:0] sum_q;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)    sum_q <= 8'h0;
      else if (restart) sum_q <= 8'h0;
      else if (accept)  sum_q <= sum_q + load_byte;
   end
   assign load_sum = sum_q;
`else
   assign load_sum = 8'h00;
`endif

   // Words beyond the current load are masked so stale contents never reach the core.
   assign pc_in_range = (pc[31:ADDR_W] == '0) && ({1'b0, pc[ADDR_W-1:0]} < word_count);
   assign instruction = (state == ST_RUN && pc_in_range) ? mem[pc[ADDR_W-1:0]] : 32'h0;

endmodule
